// File: rtl/ysyx_23060096_npc_mc.sv
// ysyx_23060096_npc_mc -- multi-cycle RV32I subset core (single clock).
// Executes add, sub, addi, lui, auipc, jal, jalr, beq, bne, lw, sw, ebreak.
// Any other encoding stops the core with halt_code = 32'hFFFF_FFFF.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr    fetch request (address = pc)
//   imem_rsp_valid, imem_rdata         fetch response
//   dmem_req_valid/ready, dmem_we,
//   dmem_addr, dmem_wdata              data request (word aligned)
//   dmem_rsp_valid, dmem_rdata         load data / store completion
//   pc, halt, halt_code                architectural status
module ysyx_23060096_npc_mc #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          NR_REGS  = 32
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] pc,
   output logic        halt,
   output logic [31:0] halt_code
);

   // Register index width; upper index bits of rs/rd fields are ignored.
   localparam int IW = (NR_REGS == 16) ? 4 : 5;
   localparam logic [IW-1:0] A0_IDX = IW'(10);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   typedef enum logic [2:0] {
      IF_REQ  = 3'd0,
      IF_WAIT = 3'd1,
      EX      = 3'd2,
      LS_REQ  = 3'd3,
      LS_WAIT = 3'd4,
      HALT    = 3'd5
   } state_t;

   state_t         state_r;
   logic [31:0]    pc_r;
   logic [31:0]    ir_r;
   logic [31:0]    gpr_r [NR_REGS];
   logic           imem_req_valid_r;
   logic           dmem_req_valid_r;
   logic           dmem_we_r;
   logic [31:0]    dmem_addr_r;
   logic [31:0]    dmem_wdata_r;
   logic [IW-1:0]  ld_rd_r;
   logic           halt_r;
   logic [31:0]    halt_code_r;

   logic [6:0]     opcode_s;
   logic [2:0]     f3_s;
   logic [6:0]     f7_s;
   logic [IW-1:0]  rd_idx_s;
   logic [IW-1:0]  rs1_idx_s;
   logic [IW-1:0]  rs2_idx_s;
   logic [31:0]    rs1_val_s;
   logic [31:0]    rs2_val_s;
   logic [31:0]    imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
   logic [31:0]    pc_plus4_s;
   logic           wb_en_s;
   logic [31:0]    wb_data_s;
   logic [31:0]    next_pc_s;
   logic           mem_op_s;
   logic           store_s;
   logic [31:0]    mem_addr_s;
   logic           ebreak_s;
   logic           illegal_s;

   assign opcode_s   = ir_r[6:0];
   assign f3_s       = ir_r[14:12];
   assign f7_s       = ir_r[31:25];
   assign rd_idx_s   = ir_r[7 +: IW];
   assign rs1_idx_s  = ir_r[15 +: IW];
   assign rs2_idx_s  = ir_r[20 +: IW];
   assign rs1_val_s  = gpr_r[rs1_idx_s];
   assign rs2_val_s  = gpr_r[rs2_idx_s];
   assign imm_i_s    = {{20{ir_r[31]}}, ir_r[31:20]};
   assign imm_s_s    = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
   assign imm_b_s    = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
   assign imm_u_s    = {ir_r[31:12], 12'h000};
   assign imm_j_s    = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
   assign pc_plus4_s = pc_r + 32'd4;

   assign imem_req_valid = imem_req_valid_r;
   assign imem_addr      = pc_r;
   assign dmem_req_valid = dmem_req_valid_r;
   assign dmem_we        = dmem_we_r;
   assign dmem_addr      = dmem_addr_r;
   assign dmem_wdata     = dmem_wdata_r;
   assign pc             = pc_r;
   assign halt           = halt_r;
   assign halt_code      = halt_code_r;

   // Decode the instruction register and compute the EX-stage results.
   always_comb begin
      wb_en_s    = 1'b0;
      wb_data_s  = 32'h0000_0000;
      next_pc_s  = pc_plus4_s;
      mem_op_s   = 1'b0;
      store_s    = 1'b0;
      mem_addr_s = rs1_val_s + imm_i_s;
      ebreak_s   = 1'b0;
      illegal_s  = 1'b0;
      case (opcode_s)
         OP_R: begin
            if ((f3_s == 3'b000) && (f7_s == 7'b0000000)) begin
               wb_en_s   = 1'b1;
               wb_data_s = rs1_val_s + rs2_val_s;
            end else if ((f3_s == 3'b000) && (f7_s == 7'b0100000)) begin
               wb_en_s   = 1'b1;
               wb_data_s = rs1_val_s - rs2_val_s;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_IMM: begin
            if (f3_s == 3'b000) begin
               wb_en_s   = 1'b1;
               wb_data_s = rs1_val_s + imm_i_s;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_LUI: begin
            wb_en_s   = 1'b1;
            wb_data_s = imm_u_s;
         end
         OP_AUIPC: begin
            wb_en_s   = 1'b1;
            wb_data_s = pc_r + imm_u_s;
         end
         OP_JAL: begin
            wb_en_s   = 1'b1;
            wb_data_s = pc_plus4_s;
            next_pc_s = pc_r + imm_j_s;
         end
         OP_JALR: begin
            if (f3_s == 3'b000) begin
               wb_en_s   = 1'b1;
               wb_data_s = pc_plus4_s;
               next_pc_s = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_BRANCH: begin
            if (f3_s == 3'b000) begin
               if (rs1_val_s == rs2_val_s) begin
                  next_pc_s = pc_r + imm_b_s;
               end else begin
                  next_pc_s = pc_plus4_s;
               end
            end else if (f3_s == 3'b001) begin
               if (rs1_val_s != rs2_val_s) begin
                  next_pc_s = pc_r + imm_b_s;
               end else begin
                  next_pc_s = pc_plus4_s;
               end
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_LOAD: begin
            if (f3_s == 3'b010) begin
               mem_op_s = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_STORE: begin
            if (f3_s == 3'b010) begin
               mem_op_s   = 1'b1;
               store_s    = 1'b1;
               mem_addr_s = rs1_val_s + imm_s_s;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_SYSTEM: begin
            if (ir_r == EBREAK) begin
               ebreak_s = 1'b1;
            end else begin
               illegal_s = 1'b1;
            end
         end
         default: illegal_s = 1'b1;
      endcase
   end

   // Control FSM, register file and all registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r          <= IF_REQ;
         pc_r             <= RESET_PC;
         ir_r             <= 32'h0000_0000;
         imem_req_valid_r <= 1'b0;
         dmem_req_valid_r <= 1'b0;
         dmem_we_r        <= 1'b0;
         dmem_addr_r      <= 32'h0000_0000;
         dmem_wdata_r     <= 32'h0000_0000;
         ld_rd_r          <= {IW{1'b0}};
         halt_r           <= 1'b0;
         halt_code_r      <= 32'h0000_0000;
         for (int i = 0; i < NR_REGS; i++) begin
            gpr_r[i] <= 32'h0000_0000;
         end
      end else begin
         case (state_r)
            IF_REQ: begin
               // The request is raised one cycle after entry; only a raised
               // request can be accepted.
               if (imem_req_valid_r && imem_req_ready) begin
                  imem_req_valid_r <= 1'b0;
                  state_r          <= IF_WAIT;
               end else begin
                  imem_req_valid_r <= 1'b1;
               end
            end
            IF_WAIT: begin
               if (imem_rsp_valid) begin
                  ir_r    <= imem_rdata;
                  state_r <= EX;
               end else begin
                  state_r <= IF_WAIT;
               end
            end
            EX: begin
               if (illegal_s) begin
                  halt_r      <= 1'b1;
                  halt_code_r <= 32'hFFFF_FFFF;
                  state_r     <= HALT;
               end else if (ebreak_s) begin
                  halt_r      <= 1'b1;
                  halt_code_r <= gpr_r[A0_IDX];
                  state_r     <= HALT;
               end else if (mem_op_s) begin
                  dmem_req_valid_r <= 1'b1;
                  dmem_we_r        <= store_s;
                  dmem_addr_r      <= mem_addr_s & 32'hFFFF_FFFC;
                  dmem_wdata_r     <= rs2_val_s;
                  // Stores target x0 so the LS_WAIT write path stays idle.
                  ld_rd_r          <= store_s ? {IW{1'b0}} : rd_idx_s;
                  state_r          <= LS_REQ;
               end else begin
                  if (wb_en_s && (rd_idx_s != {IW{1'b0}})) begin
                     gpr_r[rd_idx_s] <= wb_data_s;
                  end else begin
                     ld_rd_r <= ld_rd_r;
                  end
                  pc_r             <= next_pc_s;
                  imem_req_valid_r <= 1'b1;
                  state_r          <= IF_REQ;
               end
            end
            LS_REQ: begin
               if (dmem_req_ready) begin
                  dmem_req_valid_r <= 1'b0;
                  state_r          <= LS_WAIT;
               end else begin
                  state_r <= LS_REQ;
               end
            end
            LS_WAIT: begin
               if (dmem_rsp_valid) begin
                  if (!dmem_we_r && (ld_rd_r != {IW{1'b0}})) begin
                     gpr_r[ld_rd_r] <= dmem_rdata;
                  end else begin
                     ld_rd_r <= ld_rd_r;
                  end
                  pc_r             <= pc_plus4_s;
                  imem_req_valid_r <= 1'b1;
                  state_r          <= IF_REQ;
               end else begin
                  state_r <= LS_WAIT;
               end
            end
            HALT: begin
               state_r <= HALT;
            end
            default: begin
               // Unreachable encoding: stop safely.
               imem_req_valid_r <= 1'b0;
               dmem_req_valid_r <= 1'b0;
               halt_r           <= 1'b1;
               halt_code_r      <= 32'hFFFF_FFFF;
               state_r          <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060096_npc_mc.sv
// Testbench for ysyx_23060096_npc_mc: memories with random stalls/latencies
// and an instruction-level reference model of the architectural state.
module tb_ysyx_23060096_npc_mc;

   localparam logic [31:0] RST    = 32'h8000_0000;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk;
   logic        rstn;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_addr, imem_rdata;
   logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0] pc, halt_code;
   logic        halt;

   ysyx_23060096_npc_mc #(.RESET_PC(RST), .NR_REGS(32)) dut (
      .clk(clk), .rstn(rstn),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .pc(pc), .halt(halt), .halt_code(halt_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] imem [128];
   logic [31:0] dmem [16];

   // reference architectural state
   logic [31:0] m_x [32];
   logic [31:0] m_pc, m_code, m_daddr, m_dwdata;
   logic [4:0]  m_drd;
   bit          m_halt, m_dpend, m_dwe;

   int checks = 0;
   int failures = 0;
   int d_stall_cfg = -1;
   int d_lat_cfg = -1;
   bit abort_mode = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] e_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return e_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction

   function automatic logic [31:0] imem_rd(input logic [31:0] a);
      logic [31:0] off;
      off = a - RST;
      if (off < 32'd512) return imem[off[8:2]];
      else return 32'h0000_0000;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0000;
      for (int i = 0; i < 16; i++) dmem[i] = 32'h0000_0000;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_x[i] = 32'h0000_0000;
      m_pc = RST; m_halt = 1'b0; m_code = 32'h0000_0000; m_dpend = 1'b0;
   endtask

   task automatic wr(input logic [4:0] rd, input logic [31:0] v);
      if (rd != 5'd0) m_x[rd] = v;
   endtask

   // Executes one instruction on the reference state.
   task automatic model_exec(input logic [31:0] ins);
      logic [31:0] a, b, nx, ii, is, ib, iu, ij, t;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      bit          ill;
      a  = m_x[ins[19:15]];
      b  = m_x[ins[24:20]];
      rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu = {ins[31:12], 12'h000};
      ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      nx = m_pc + 32'd4;
      ill = 1'b0;
      if (ins == EBREAK) begin
         m_halt = 1'b1; m_code = m_x[10];
         return;
      end
      case (ins[6:0])
         7'h33: if (f3 == 3'd0 && f7 == 7'h00) wr(rd, a + b);
                else if (f3 == 3'd0 && f7 == 7'h20) wr(rd, a - b);
                else ill = 1'b1;
         7'h13: if (f3 == 3'd0) wr(rd, a + ii); else ill = 1'b1;
         7'h37: wr(rd, iu);
         7'h17: wr(rd, m_pc + iu);
         7'h6F: begin wr(rd, m_pc + 32'd4); nx = m_pc + ij; end
         7'h67: if (f3 == 3'd0) begin t = (a + ii) & 32'hFFFF_FFFE; wr(rd, m_pc + 32'd4); nx = t; end
                else ill = 1'b1;
         7'h63: if (f3 == 3'd0) begin if (a == b) nx = m_pc + ib; end
                else if (f3 == 3'd1) begin if (a != b) nx = m_pc + ib; end
                else ill = 1'b1;
         7'h03: if (f3 == 3'd2) begin
                   m_dpend = 1'b1; m_dwe = 1'b0; m_daddr = (a + ii) & 32'hFFFF_FFFC; m_drd = rd;
                end else ill = 1'b1;
         7'h23: if (f3 == 3'd2) begin
                   m_dpend = 1'b1; m_dwe = 1'b1; m_daddr = (a + is) & 32'hFFFF_FFFC; m_dwdata = b; m_drd = 5'd0;
                end else ill = 1'b1;
         default: ill = 1'b1;
      endcase
      if (ill) begin m_halt = 1'b1; m_code = 32'hFFFF_FFFF; end
      else m_pc = nx;
   endtask

   task automatic drive_idle();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = $urandom;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ireq"}, 32'(imem_req_valid), 32'd0);
      chk({tag, "_dreq"}, 32'(dmem_req_valid), 32'd0);
      chk({tag, "_halt"}, 32'(halt), 32'd0);
      chk({tag, "_code"}, halt_code, 32'd0);
      chk({tag, "_pc"}, pc, RST);
   endtask

   // Asynchronous reset pulse between clock edges, then release.
   task automatic start_prog();
      @(negedge clk);
      drive_idle();
      rstn = 1'b0;
      #1;
      check_reset_state("rst");
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      @(negedge clk);
      chk("first_fetch", 32'(imem_req_valid), 32'd1);
   endtask

   // Serves fetch/data traffic cycle by cycle until the core halts.
   task automatic run_prog(input int budget);
      bit f_busy = 1'b0, d_busy = 1'b0, done = 1'b0, abort_pending = 1'b0;
      int f_lat = 0, d_lat = 0, cyc = 0;
      int f_stall = $urandom_range(0, 2);
      int d_stall = (d_stall_cfg >= 0) ? d_stall_cfg : $urandom_range(0, 2);
      logic [31:0] f_addr = 32'h0, acc_addr = 32'h0;
      logic [4:0]  acc_rd = 5'd0;
      bit          acc_we = 1'b0;
      while (!done && cyc < budget) begin
         drive_idle();
         if (halt) begin
            chk("halt_expected", 32'(m_halt), 32'd1);
            chk("halt_code", halt_code, m_code);
            for (int k = 0; k < 20; k++) begin
               @(negedge clk);
               imem_req_ready = 1'b1; dmem_req_ready = 1'b1;
               chk("halt_no_ireq", 32'(imem_req_valid), 32'd0);
               chk("halt_no_dreq", 32'(dmem_req_valid), 32'd0);
               chk("halt_pc", pc, m_pc);
            end
            done = 1'b1;
         end else if (abort_pending) begin
            abort_pending = 1'b0; abort_mode = 1'b0;
            rstn = 1'b0;
            #1;
            check_reset_state("abort");
            for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0000;
            imem[0] = EBREAK;
            model_reset();
            f_busy = 1'b0; d_busy = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            dmem_rsp_valid = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
         end else begin
            if (imem_req_valid && dmem_req_valid) chk("req_exclusive", 32'd1, 32'd0);
            if (f_busy) begin
               if (f_lat == 0) begin
                  imem_rsp_valid = 1'b1; imem_rdata = imem_rd(f_addr);
                  model_exec(imem_rdata);
                  f_busy = 1'b0;
               end else f_lat--;
            end else if (imem_req_valid) begin
               if (m_halt) chk("fetch_after_halt", 32'd1, 32'd0);
               else if (f_stall > 0) f_stall--;
               else begin
                  imem_req_ready = 1'b1;
                  chk("fetch_addr", imem_addr, m_pc);
                  chk("pc_out", pc, m_pc);
                  f_busy = 1'b1; f_addr = imem_addr;
                  f_lat = $urandom_range(0, 2); f_stall = $urandom_range(0, 2);
                  // a response in the acceptance cycle must be ignored
                  if ($urandom_range(0, 1) == 1) begin imem_rsp_valid = 1'b1; imem_rdata = 32'h0000_0000; end
               end
            end
            if (d_busy) begin
               if (d_lat == 0) begin
                  dmem_rsp_valid = 1'b1;
                  if (!acc_we) begin
                     dmem_rdata = dmem[acc_addr[5:2]];
                     if (acc_rd != 5'd0) m_x[acc_rd] = dmem_rdata;
                  end
                  d_busy = 1'b0;
               end else d_lat--;
            end else if (dmem_req_valid) begin
               if (!m_dpend) chk("unexpected_dreq", 32'd1, 32'd0);
               else if (d_stall > 0) d_stall--;
               else begin
                  dmem_req_ready = 1'b1;
                  chk("d_we", 32'(dmem_we), 32'(m_dwe));
                  chk("d_addr", dmem_addr, m_daddr);
                  if (m_dwe) begin
                     chk("d_wdata", dmem_wdata, m_dwdata);
                     dmem[m_daddr[5:2]] = m_dwdata;
                  end
                  acc_addr = m_daddr; acc_we = m_dwe; acc_rd = m_drd; m_dpend = 1'b0;
                  d_busy = 1'b1;
                  d_lat = (d_lat_cfg >= 0) ? d_lat_cfg : $urandom_range(0, 2);
                  d_stall = (d_stall_cfg >= 0) ? d_stall_cfg : $urandom_range(0, 2);
                  if (abort_mode) abort_pending = 1'b1;
                  if ($urandom_range(0, 1) == 1) begin dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
               end
            end
         end
         @(negedge clk);
         cyc++;
      end
      chk("prog_done", 32'(done), 32'd1);
   endtask

   task automatic gen_random();
      clear_mem();
      for (int i = 0; i < 16; i++) dmem[i] = $urandom;
      for (int i = 0; i < 40; i++) begin
         logic [4:0] rd, rs1, rs2;
         int k;
         rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
         k = $urandom_range(0, 9);
         case (k)
            2: imem[i] = e_r(7'h00, rs2, rs1, 3'd0, rd, 7'h33);
            3: imem[i] = e_r(7'h20, rs2, rs1, 3'd0, rd, 7'h33);
            4: imem[i] = e_u(20'($urandom), rd, 7'h37);
            5: imem[i] = e_u(20'($urandom), rd, 7'h17);
            6: imem[i] = e_s(12'($urandom_range(0, 15) * 4), rs2, 5'd0);
            7: imem[i] = e_i(12'($urandom_range(0, 15) * 4), 5'd0, 3'b010, rd, 7'h03);
            8: imem[i] = e_b(13'd8, rs2, rs1, 3'($urandom_range(0, 1)));
            9: imem[i] = e_j(21'd8, rd);
            default: imem[i] = addi(rd, rs1, 12'($urandom));
         endcase
      end
      imem[40] = e_r(7'h00, 5'd0, 5'($urandom_range(1, 7)), 3'd0, 5'd10, 7'h33);
      imem[41] = EBREAK;
   endtask

   initial begin
      rstn = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);

      // addi chain, then sw/lw with 3-cycle ready stall and 2-cycle latency
      clear_mem();
      imem[0] = addi(5'd1, 5'd0, 12'd5);
      imem[1] = addi(5'd2, 5'd1, 12'hFF9);
      imem[2] = e_s(12'd4, 5'd2, 5'd0);
      imem[3] = e_i(12'd4, 5'd0, 3'b010, 5'd3, 7'h03);
      imem[4] = e_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd10, 7'h33);
      imem[5] = EBREAK;
      d_stall_cfg = 3; d_lat_cfg = 1;
      start_prog();
      run_prog(500);
      chk("ls_code", halt_code, 32'hFFFF_FFFE);
      chk("ls_mem", dmem[1], 32'hFFFF_FFFE);
      d_stall_cfg = -1; d_lat_cfg = -1;

      // backward taken branch
      clear_mem();
      imem[0] = e_j(21'd16, 5'd0);
      imem[2] = addi(5'd10, 5'd0, 12'd77);
      imem[3] = EBREAK;
      imem[4] = e_b(13'h1FF8, 5'd0, 5'd0, 3'd0);
      start_prog();
      run_prog(300);
      chk("beq_code", halt_code, 32'd77);

      // jalr with odd target
      clear_mem();
      imem[0]  = e_u(20'h80000, 5'd5, 7'h37);
      imem[1]  = addi(5'd5, 5'd5, 12'h100);
      imem[2]  = e_i(12'd3, 5'd5, 3'd0, 5'd1, 7'h67);
      imem[64] = e_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd10, 7'h33);
      imem[65] = EBREAK;
      start_prog();
      run_prog(300);
      chk("jalr_code", halt_code, 32'h8000_000C);

      // x0 stays zero
      clear_mem();
      imem[0] = addi(5'd10, 5'd0, 12'd5);
      imem[1] = addi(5'd0, 5'd0, 12'd9);
      imem[2] = e_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4, 7'h33);
      imem[3] = e_r(7'h00, 5'd4, 5'd4, 3'd0, 5'd10, 7'h33);
      imem[4] = EBREAK;
      start_prog();
      run_prog(300);
      chk("x0_code", halt_code, 32'd0);

      // li a0,42; ebreak
      clear_mem();
      imem[0] = addi(5'd10, 5'd0, 12'd42);
      imem[1] = EBREAK;
      start_prog();
      run_prog(200);
      chk("ebreak_code", halt_code, 32'd42);

      // all-zero word is illegal
      clear_mem();
      start_prog();
      run_prog(200);
      chk("illegal0_code", halt_code, 32'hFFFF_FFFF);

      // bad funct3 on a register op is illegal
      clear_mem();
      imem[0] = addi(5'd10, 5'd0, 12'd3);
      imem[1] = e_r(7'h20, 5'd1, 5'd1, 3'd1, 5'd2, 7'h33);
      start_prog();
      run_prog(200);
      chk("illegal_f3_code", halt_code, 32'hFFFF_FFFF);

      // reset during LS_WAIT, late response afterwards must be dropped
      clear_mem();
      dmem[0] = 32'h0000_0055;
      imem[0] = addi(5'd10, 5'd0, 12'd9);
      imem[1] = e_i(12'd0, 5'd0, 3'b010, 5'd10, 7'h03);
      imem[2] = EBREAK;
      abort_mode = 1'b1;
      start_prog();
      run_prog(300);
      chk("abort_code", halt_code, 32'd0);
      abort_mode = 1'b0;

      // randomized programs against the reference model
      for (int r = 0; r < 4; r++) begin
         gen_random();
         start_prog();
         run_prog(3000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
